byte_packer_fifo: RTL and testbench
===================================

// Module: byte_packer_fifo
//
// PURPOSE
// - Packs a variable number of bytes per clock (1..IN_BYTES) into OUT_BYTES-wide words, MSB-first, and buffers them in a single-clock FIFO.
// - Flush may share a cycle with a write, flushed partial words carry a valid-byte count, and an empty-staging flush writes nothing.
// - The producer sees a wr_ready backpressure output.
// - Sits between byte-granular protocol parsers (e.g. Ethernet/UART framers) and word-wide consumers/DMA.
//
// PARAMETERS
// - IN_BYTES   4    max bytes accepted per write; must be 1..OUT_BYTES
// - OUT_BYTES  4    bytes per output word; must be >= 1
// - DEPTH      512  FIFO depth in words; ADDR_BITS = $clog2(DEPTH)
// - USE_BLOCK  1    passed through to SingleClockFifo (block RAM vs distributed)
// - OUT_REG    1    passed through to SingleClockFifo (registered read data)
//
// PORTS
// - clk          in   1                  single clock; all logic is posedge
// - reset        in   1                  asynchronous, active-high; clears all state
// - wr           in   1                  write strobe; qualified by wr_ready
// - din          in   IN_BYTES*8         input bytes, left-justified: first byte in din[MSB -: 8]
// - bytes_valid  in   $clog2(IN_BYTES+1) number of valid bytes in din (0 = no-op)
// - flush        in   1                  push staged bytes as a (possibly partial) word; legal with wr
// - wr_ready     out  1                  staging can accept wr/flush this cycle
// - rd           in   1                  FIFO read strobe
// - dout         out  OUT_BYTES*8        packed word, left-justified, unused low bytes zero
// - dout_bytes   out  $clog2(OUT_BYTES+1) valid bytes in dout (OUT_BYTES for full words)
// - empty        out  1                  FIFO empty
// - full         out  1                  FIFO full
// - rsize        out  ADDR_BITS+1        words readable
// - wsize        out  ADDR_BITS+1        words writable
// - overflow     out  1                  1-cycle pulse: input dropped (wr/flush while !wr_ready, or FIFO full on push)
// - underflow    out  1                  1-cycle pulse from FIFO: rd while empty
//
// BEHAVIOUR
// - Reset values: wr_ready=0 during reset, then 1; overflow=underflow=0; empty=1, full=0, rsize=0, wsize=DEPTH.
// - Staging: up to OUT_BYTES-1 bytes plus a count. Per accepted cycle:
//   - merged = staged bytes followed by din[bytes_valid].
//   - If merged count >= OUT_BYTES: push the top OUT_BYTES with dout_bytes=OUT_BYTES; the remainder stays staged.
//   - At most one push per cycle, guaranteed by IN_BYTES <= OUT_BYTES.
// - Latency: the accepted write in cycle N causes a FIFO write at the edge ending N+1; empty/rsize then follow SingleClockFifo timing.
// - FSM ACCUM / FLUSH_PEND:
//   - ACCUM, flush with merged count in 1..OUT_BYTES: push merged (partial or full) with its count, clear staging, stay ACCUM.
//   - ACCUM, flush with merged > OUT_BYTES: push full word now, keep the remainder, go to FLUSH_PEND.
//   - FLUSH_PEND: push the remainder as a partial word next cycle, clear staging, return to ACCUM; wr_ready=0 throughout.
//   - Flush with merged == 0: no FIFO write.
// - wr_ready = (state==ACCUM) && (wsize >= 2) && !reset. The margin of 2 covers the FLUSH_PEND second push and one write in flight.
// - wr or flush while !wr_ready: input ignored, staging unchanged, overflow pulses next cycle.
// - bytes_valid > IN_BYTES is illegal; the design clamps it to IN_BYTES.
// - Reset mid-operation (async): staging, count, FSM, pending push and FIFO pointers are cleared immediately; staged bytes are lost.
// - Simultaneous rd and push on a full FIFO is handled per SingleClockFifo. wr_ready prevents this case in normal use.
//
// STRUCTURE
// - Package byte_packer_pkg:
//   - typedef enum {ACCUM, FLUSH_PEND} packer_state_t
//   - function count_width(n) = $clog2(n+1)
// - Sub-module: SingleClockFifo (existing), WIDTH = OUT_BYTES*8 + count_width(OUT_BYTES).
//   - {word, byte_count} is stored per entry; dout and dout_bytes are split from its output.
// - The SingleClockFifo reset input gets the async reset. The local merge/staging logic is a comb merge plus one always_ff with async reset.
//
// TESTING
// - IN=4, OUT=4: write 1,3,2,2 bytes of 0x01..0x08.
//   -> two words 0x01020304, 0x05060708, each with dout_bytes=4; staging empty afterwards.
// - Stage 3 bytes AA BB CC, then flush with no wr.
//   -> one word 0xAABBCC00 with dout_bytes=3; a second flush writes nothing (rsize unchanged).
// - 3 bytes staged, wr of 4 bytes plus flush in the same cycle.
//   -> full word at N+1, partial word with dout_bytes=3 at N+2, wr_ready=0 for cycle N+1.
// - Fill the FIFO to DEPTH-1 words.
//   -> wr_ready falls once wsize<2; a wr while !wr_ready gives an overflow pulse and no data corruption.
// - IN=2, OUT=8: stream 100 random 1..2-byte writes and flush.
//   -> the byte stream read back equals the input, and the final dout_bytes equals total mod 8 (or 8 if the total is a multiple of 8).
// - Assert reset asynchronously between clock edges with 2 bytes staged.
//   -> empty=1 at once, and after release the first word contains only new bytes.

Source files
------------

// File: rtl/byte_packer_pkg.sv
// Shared types and helpers for the byte packer and its FIFO.
package byte_packer_pkg;

  typedef enum logic {
    ACCUM      = 1'b0,
    FLUSH_PEND = 1'b1
  } packer_state_t;

  // Bits needed to hold a count in 0..n.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/byte_packer_fifo_single_clock_fifo.sv
// Single-clock FIFO with occupancy outputs and drop/empty-read pulse flags.
module SingleClockFifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 512,
  parameter int USE_BLOCK = 1,
  parameter int OUT_REG   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   rsize,
  output logic [$clog2(DEPTH):0]   wsize,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int  ADDR_BITS = $clog2(DEPTH);
  // Block RAM needs a synchronous read port, so either option registers dout.
  localparam bit  SYNC_READ = (USE_BLOCK != 0) || (OUT_REG != 0);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [ADDR_BITS-1:0] wptr, rptr;
  logic [ADDR_BITS:0]   count;
  logic                 do_wr, do_rd;

  function automatic logic [ADDR_BITS-1:0] next_ptr(input logic [ADDR_BITS-1:0] p);
    return (p == ADDR_BITS'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count == '0);
  assign full  = (count == (ADDR_BITS + 1)'(DEPTH));
  assign rsize = count;
  assign wsize = (ADDR_BITS + 1)'(DEPTH) - count;
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_wr) wptr <= next_ptr(wptr);
      if (do_rd) rptr <= next_ptr(rptr);
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (!do_wr && do_rd) count <= count - 1'b1;
      overflow  <= wr && full;
      underflow <= rd && empty;
    end
  end

  // NOTE: storage has no reset; pointers and count define which entries are valid,
  // and a resettable array would block RAM inference.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= din;
  end

  if (SYNC_READ) begin : g_sync_read
    always_ff @(posedge clk or posedge reset) begin
      if (reset)      dout <= '0;
      else if (do_rd) dout <= mem[rptr];
    end
  end else begin : g_async_read
    assign dout = mem[rptr];
  end

endmodule

// File: rtl/byte_packer_fifo.sv
// Packs 1..IN_BYTES bytes per cycle MSB-first into OUT_BYTES words and queues them.
module byte_packer_fifo
  import byte_packer_pkg::*;
#(
  parameter int IN_BYTES  = 4,
  parameter int OUT_BYTES = 4,
  parameter int DEPTH     = 512,
  parameter int USE_BLOCK = 1,
  parameter int OUT_REG   = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wr,
  input  logic [IN_BYTES*8-1:0]              din,
  input  logic [count_width(IN_BYTES)-1:0]   bytes_valid,
  input  logic                               flush,
  output logic                               wr_ready,
  input  logic                               rd,
  output logic [OUT_BYTES*8-1:0]             dout,
  output logic [count_width(OUT_BYTES)-1:0]  dout_bytes,
  output logic                               empty,
  output logic                               full,
  output logic [$clog2(DEPTH):0]             rsize,
  output logic [$clog2(DEPTH):0]             wsize,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int IW = count_width(IN_BYTES);
  localparam int OW = count_width(OUT_BYTES);
  localparam int WB = OUT_BYTES * 8;
  localparam int MB = 2 * WB;
  localparam int AB = $clog2(DEPTH);

  packer_state_t  state, state_nxt;
  logic [WB-1:0]  stage_data, stage_nxt;
  logic [OW-1:0]  stage_cnt, stage_cnt_nxt;
  logic           push_valid, push_nxt;
  logic [WB-1:0]  push_word, push_word_nxt;
  logic [OW-1:0]  push_cnt, push_cnt_nxt;
  logic           overflow_q, fifo_overflow;
  logic [IW-1:0]  take;
  logic [MB-1:0]  in_wide, merged;
  logic [OW:0]    merged_cnt;
  logic           accept;
  logic [WB+OW-1:0] fifo_q;

  assign wr_ready = (state == ACCUM) && (wsize >= (AB + 1)'(2)) && !reset;
  assign accept   = wr_ready && (wr || flush);

  // Oversized byte counts are clamped rather than trusted.
  assign take = !wr ? '0 : (bytes_valid > IW'(IN_BYTES)) ? IW'(IN_BYTES) : bytes_valid;

  always_comb begin
    in_wide = '0;
    for (int i = 0; i < IN_BYTES; i++)
      if (IW'(i) < take) in_wide[MB-1-8*i -: 8] = din[IN_BYTES*8-1-8*i -: 8];
  end

  // Staged bytes are left-justified with zeros below, so new bytes OR in behind them.
  assign merged     = {stage_data, {WB{1'b0}}} | (in_wide >> (8 * stage_cnt));
  assign merged_cnt = (OW + 1)'(stage_cnt) + (OW + 1)'(take);

  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_nxt     = state;
    stage_nxt     = stage_data;
    stage_cnt_nxt = stage_cnt;
    push_nxt      = 1'b0;
    push_word_nxt = merged[MB-1 -: WB];
    push_cnt_nxt  = OW'(OUT_BYTES);
    case (state)
      ACCUM: begin
        if (accept) begin
          if (merged_cnt >= (OW + 1)'(OUT_BYTES)) begin
            push_nxt      = 1'b1;
            stage_nxt     = merged[MB-WB-1:0];
            stage_cnt_nxt = OW'(merged_cnt - (OW + 1)'(OUT_BYTES));
            if (flush && merged_cnt > (OW + 1)'(OUT_BYTES)) state_nxt = FLUSH_PEND;
          end else if (flush && merged_cnt != '0) begin
            push_nxt      = 1'b1;
            push_cnt_nxt  = OW'(merged_cnt);
            stage_nxt     = '0;
            stage_cnt_nxt = '0;
          end else begin
            stage_nxt     = merged[MB-1 -: WB];
            stage_cnt_nxt = OW'(merged_cnt);
          end
        end
      end
      FLUSH_PEND: begin
        push_nxt      = 1'b1;
        push_word_nxt = stage_data;
        push_cnt_nxt  = stage_cnt;
        stage_nxt     = '0;
        stage_cnt_nxt = '0;
        state_nxt     = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ACCUM;
      stage_data <= '0;
      stage_cnt  <= '0;
      push_valid <= 1'b0;
      push_word  <= '0;
      push_cnt   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      stage_data <= stage_nxt;
      stage_cnt  <= stage_cnt_nxt;
      push_valid <= push_nxt;
      push_word  <= push_word_nxt;
      push_cnt   <= push_cnt_nxt;
      overflow_q <= (wr || flush) && !wr_ready;
    end
  end

  SingleClockFifo #(
    .WIDTH    (WB + OW),
    .DEPTH    (DEPTH),
    .USE_BLOCK(USE_BLOCK),
    .OUT_REG  (OUT_REG)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr       (push_valid),
    .din      ({push_word, push_cnt}),
    .rd       (rd),
    .dout     (fifo_q),
    .empty    (empty),
    .full     (full),
    .rsize    (rsize),
    .wsize    (wsize),
    .overflow (fifo_overflow),
    .underflow(underflow)
  );

  assign dout       = fifo_q[WB+OW-1 -: WB];
  assign dout_bytes = fifo_q[OW-1:0];
  assign overflow   = overflow_q || fifo_overflow;

endmodule

// File: tb/tb_byte_packer_fifo.sv
// Bench for byte_packer_fifo: 4->4 and 2->8 instances against a byte-queue model.
module tb_byte_packer_fifo;

  typedef struct {
    logic [63:0] word;
    int          cnt;
  } word_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance A: IN=4, OUT=4, DEPTH=512
  logic        a_wr = 0, a_flush = 0, a_rd = 0;
  logic [31:0] a_din = '0;
  logic [2:0]  a_bv = '0;
  logic        a_ready, a_empty, a_full, a_ovf, a_unf;
  logic [31:0] a_dout;
  logic [2:0]  a_dout_bytes;
  logic [9:0]  a_rsize, a_wsize;

  // Instance B: IN=2, OUT=8, DEPTH=32
  logic        b_wr = 0, b_flush = 0, b_rd = 0;
  logic [15:0] b_din = '0;
  logic [1:0]  b_bv = '0;
  logic        b_ready, b_empty, b_full, b_ovf, b_unf;
  logic [63:0] b_dout;
  logic [3:0]  b_dout_bytes;
  logic [5:0]  b_rsize, b_wsize;

  byte_packer_fifo #(.IN_BYTES(4), .OUT_BYTES(4), .DEPTH(512), .USE_BLOCK(1), .OUT_REG(1)) dut_a (
    .clk(clk), .reset(reset), .wr(a_wr), .din(a_din), .bytes_valid(a_bv), .flush(a_flush),
    .wr_ready(a_ready), .rd(a_rd), .dout(a_dout), .dout_bytes(a_dout_bytes), .empty(a_empty),
    .full(a_full), .rsize(a_rsize), .wsize(a_wsize), .overflow(a_ovf), .underflow(a_unf)
  );

  byte_packer_fifo #(.IN_BYTES(2), .OUT_BYTES(8), .DEPTH(32), .USE_BLOCK(1), .OUT_REG(1)) dut_b (
    .clk(clk), .reset(reset), .wr(b_wr), .din(b_din), .bytes_valid(b_bv), .flush(b_flush),
    .wr_ready(b_ready), .rd(b_rd), .dout(b_dout), .dout_bytes(b_dout_bytes), .empty(b_empty),
    .full(b_full), .rsize(b_rsize), .wsize(b_wsize), .overflow(b_ovf), .underflow(b_unf)
  );

  int total = 0;
  int bad = 0;

  logic [7:0] stg_a[$], stg_b[$];
  word_t      exp_a[$], exp_b[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference model: bytes queue up; every OUT bytes form a word; flush emits the rest.
  task automatic emit(input int u);
    word_t w;
    w.word = '0;
    if (u == 0) begin
      w.cnt = stg_a.size();
      for (int i = 0; i < 4; i++) w.word = (w.word << 8) | 64'(i < stg_a.size() ? stg_a[i] : 8'h00);
      stg_a.delete();
      exp_a.push_back(w);
    end else begin
      w.cnt = stg_b.size();
      for (int i = 0; i < 8; i++) w.word = (w.word << 8) | 64'(i < stg_b.size() ? stg_b[i] : 8'h00);
      stg_b.delete();
      exp_b.push_back(w);
    end
  endtask

  task automatic model_byte(input int u, input logic [7:0] b);
    if (u == 0) begin
      stg_a.push_back(b);
      if (stg_a.size() == 4) emit(0);
    end else begin
      stg_b.push_back(b);
      if (stg_b.size() == 8) emit(1);
    end
  endtask

  task automatic model_flush(input int u);
    if (u == 0 && stg_a.size() > 0) emit(0);
    if (u == 1 && stg_b.size() > 0) emit(1);
  endtask

  task automatic drive_a(input logic w, input logic [2:0] bv, input logic [31:0] data,
                         input logic fl, input bit upd);
    int n;
    a_wr = w; a_bv = bv; a_din = data; a_flush = fl;
    if (upd) begin
      n = !w ? 0 : (bv > 3'd4) ? 4 : int'(bv);
      for (int i = 0; i < n; i++) model_byte(0, data[31-8*i -: 8]);
      if (fl) model_flush(0);
    end
    tick();
    a_wr = 0; a_bv = '0; a_din = '0; a_flush = 0;
  endtask

  task automatic drive_b(input logic w, input logic [1:0] bv, input logic [15:0] data, input logic fl);
    b_wr = w; b_bv = bv; b_din = data; b_flush = fl;
    if (w) for (int i = 0; i < int'(bv); i++) model_byte(1, data[15-8*i -: 8]);
    if (fl) model_flush(1);
    tick();
    b_wr = 0; b_bv = '0; b_din = '0; b_flush = 0;
  endtask

  task automatic pop_a(input string tag);
    word_t w;
    if (exp_a.size() == 0) begin
      total++; bad++;
      $error("FAIL %s observed=extra-read expected=no-word-left", tag);
      return;
    end
    a_rd = 1; tick(); a_rd = 0;
    w = exp_a.pop_front();
    check({tag, "_data"}, 64'(a_dout), w.word);
    check({tag, "_cnt"}, 64'(a_dout_bytes), 64'(w.cnt));
  endtask

  task automatic pop_b(input string tag);
    word_t w;
    if (exp_b.size() == 0) begin
      total++; bad++;
      $error("FAIL %s observed=extra-read expected=no-word-left", tag);
      return;
    end
    b_rd = 1; tick(); b_rd = 0;
    w = exp_b.pop_front();
    check({tag, "_data"}, b_dout, w.word);
    check({tag, "_cnt"}, 64'(b_dout_bytes), 64'(w.cnt));
  endtask

  task automatic drain_a(input string tag);
    int n;
    n = exp_a.size();
    check({tag, "_rsize"}, 64'(a_rsize), 64'(n));
    for (int i = 0; i < n; i++) pop_a(tag);
    check({tag, "_empty"}, 64'(a_empty), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb, tot, last_cnt;
    logic [2:0] n;

    // Reset values
    tick(); tick();
    check("rst_ready", 64'(a_ready), 64'(0));
    check("rst_empty", 64'(a_empty), 64'(1));
    check("rst_full", 64'(a_full), 64'(0));
    check("rst_rsize", 64'(a_rsize), 64'(0));
    check("rst_wsize", 64'(a_wsize), 64'(512));
    check("rst_ovf", 64'(a_ovf), 64'(0));
    check("rst_unf", 64'(a_unf), 64'(0));
    check("rst_b_wsize", 64'(b_wsize), 64'(32));
    reset = 0;
    tick();
    check("post_rst_ready", 64'(a_ready), 64'(1));

    // 1,3,2,2 bytes of 01..08 with junk in the unused low bytes
    drive_a(1, 3'd1, {8'h01, 24'($urandom)}, 0, 1);
    drive_a(1, 3'd3, {24'h020304, 8'($urandom)}, 0, 1);
    drive_a(1, 3'd2, {16'h0506, 16'($urandom)}, 0, 1);
    drive_a(1, 3'd2, {16'h0708, 16'($urandom)}, 0, 1);
    tick(); tick();
    check("t1_w0_const", exp_a[0].word, 64'h01020304);
    drain_a("t1");

    // Partial flush, then an empty flush that writes nothing
    drive_a(1, 3'd3, 32'hAABBCC11, 0, 1);
    drive_a(0, 3'd0, 32'h0, 1, 1);
    tick(); tick();
    check("t2_rsize1", 64'(a_rsize), 64'(1));
    drive_a(0, 3'd0, 32'h0, 1, 1);
    tick(); tick();
    check("t2_rsize_same", 64'(a_rsize), 64'(1));
    check("t2_w_const", exp_a[0].word, 64'hAABBCC00);
    drain_a("t2");

    // 3 staged + 4-byte write with flush: full word, then partial; wr during FLUSH_PEND drops
    drive_a(1, 3'd3, 32'h112233FF, 0, 1);
    drive_a(1, 3'd4, 32'h44556677, 1, 1);
    check("t3_ready_n1", 64'(a_ready), 64'(0));
    check("t3_rsize_n1", 64'(a_rsize), 64'(0));
    drive_a(1, 3'd2, 32'hEEFF0000, 0, 0);
    check("t3_ovf", 64'(a_ovf), 64'(1));
    check("t3_rsize_n2", 64'(a_rsize), 64'(1));
    check("t3_ready_n2", 64'(a_ready), 64'(1));
    tick();
    check("t3_ovf_clear", 64'(a_ovf), 64'(0));
    check("t3_rsize_n3", 64'(a_rsize), 64'(2));
    drain_a("t3");

    // Random writes, occasional flush, oversized bytes_valid clamps to 4
    drive_a(1, 3'd7, 32'hC1C2C3C4, 0, 1);
    for (int i = 0; i < 40; i++) begin
      n = 3'($urandom_range(0, 4));
      check("rnd_ready", 64'(a_ready), 64'(1));
      if ($urandom_range(0, 7) == 0) begin
        drive_a(1, n, $urandom, 1, 1);
        tick();
      end else begin
        drive_a(1, n, $urandom, 0, 1);
      end
    end
    drive_a(0, 3'd0, 32'h0, 1, 1);
    tick(); tick(); tick();
    drain_a("rnd");

    // Fill to DEPTH-1 words, then a dropped write
    for (int k = 0; k < 511; k++) begin
      check("fill_ready", 64'(a_ready), 64'(1));
      drive_a(1, 3'd4, $urandom, 0, 1);
      tick();
    end
    check("fill_rsize", 64'(a_rsize), 64'(511));
    check("fill_wsize", 64'(a_wsize), 64'(1));
    check("fill_ready_low", 64'(a_ready), 64'(0));
    check("fill_full", 64'(a_full), 64'(0));
    drive_a(1, 3'd4, 32'hBAD0BAD0, 0, 0);
    check("fill_ovf", 64'(a_ovf), 64'(1));
    tick(); tick();
    check("fill_ovf_clear", 64'(a_ovf), 64'(0));
    drain_a("fill");

    // Read while empty
    a_rd = 1; tick(); a_rd = 0;
    check("unf_pulse", 64'(a_unf), 64'(1));
    tick();
    check("unf_clear", 64'(a_unf), 64'(0));

    // IN=2, OUT=8 random stream then flush
    tot = 0;
    for (int i = 0; i < 100; i++) begin
      nb = $urandom_range(1, 2);
      tot += nb;
      drive_b(1, 2'(nb), 16'($urandom), 0);
    end
    drive_b(0, 2'd0, 16'h0, 1);
    tick(); tick(); tick();
    check("b_rsize", 64'(b_rsize), 64'((tot + 7) / 8));
    last_cnt = (tot % 8 == 0) ? 8 : tot % 8;
    while (exp_b.size() > 1) pop_b("b_stream");
    pop_b("b_last");
    check("b_last_cnt", 64'(b_dout_bytes), 64'(last_cnt));
    check("b_empty", 64'(b_empty), 64'(1));

    // Asynchronous reset between edges with 2 bytes staged
    drive_a(1, 3'd4, 32'hCAFEF00D, 0, 1);
    tick(); tick();
    drive_a(1, 3'd2, 32'hDEAD0000, 0, 1);
    check("ar_pre_empty", 64'(a_empty), 64'(0));
    #2 reset = 1;
    #1;
    check("ar_empty", 64'(a_empty), 64'(1));
    check("ar_rsize", 64'(a_rsize), 64'(0));
    check("ar_ready", 64'(a_ready), 64'(0));
    stg_a.delete(); exp_a.delete(); stg_b.delete(); exp_b.delete();
    tick();
    reset = 0;
    #1;
    check("ar_ready_rel", 64'(a_ready), 64'(1));
    tick();
    drive_a(1, 3'd4, 32'h10203040, 0, 1);
    tick(); tick();
    check("ar_w_const", exp_a[0].word, 64'h10203040);
    drain_a("ar_new");
    drive_a(0, 3'd0, 32'h0, 1, 1);
    tick(); tick();
    check("ar_no_stale", 64'(a_rsize), 64'(exp_a.size()));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
